multicycle_control: RTL and testbench

Multi-cycle control sequencer for the RISC-V datapath. Accepts one instruction at a time over a valid/ready handshake and decodes R-type, I-type ALU, `lw` and `sw`. Steps the datapath through DECODE, EXEC, MEM and WB states, driving the datapath control inputs RegWrite, ALUSrc, ALUop, MemWrite, MemRead and MemtoReg. Sits between the instruction source and the datapath top, replacing the static control values applied there today.

---
 rtl/multicycle_control_if.sv | 32 +++
 rtl/multicycle_control.sv | 128 ++++++++++++
 tb/tb_multicycle_control.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Instruction/control bundle between the instruction source,
// the multi-cycle sequencer and the datapath.
interface multicycle_control_if #(
    parameter int RETIRE_W = 16
);
    logic                instr_valid;
    logic [31:0]         instr_in;
    logic                instr_ready;
    logic                mem_ready;
    logic [31:0]         instruction;
    logic                RegWrite;
    logic                ALUSrc;
    logic [3:0]          ALUop;
    logic                MemWrite;
    logic                MemRead;
    logic                MemtoReg;
    logic                done;
    logic                illegal;
    logic [RETIRE_W-1:0] retired;

    modport master (
        output instr_valid, instr_in, mem_ready,
        input  instr_ready, instruction, RegWrite, ALUSrc, ALUop,
        input  MemWrite, MemRead, MemtoReg, done, illegal, retired
    );

    modport slave (
        input  instr_valid, instr_in, mem_ready,
        output instr_ready, instruction, RegWrite, ALUSrc, ALUop,
        output MemWrite, MemRead, MemtoReg, done, illegal, retired
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle control sequencer: IDLE/DECODE/EXEC/MEM/WB for
// R-type, I-type ALU, lw and sw.
module multicycle_control #(
    parameter int RETIRE_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    multicycle_control_if.slave bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] DECODE = 3'd1;
    localparam logic [2:0] EXEC   = 3'd2;
    localparam logic [2:0] MEM    = 3'd3;
    localparam logic [2:0] WB     = 3'd4;

    logic [2:0]          state;
    logic [2:0]          state_nx;
    logic [31:0]         instr_q;
    logic [RETIRE_W-1:0] retired_q;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rd;
    logic       op_r;
    logic       op_i;
    logic       op_lw;
    logic       op_sw;
    logic [3:0] f3_op;
    logic       f3_ok;
    logic       legal;
    logic [3:0] dec_op;
    logic       dec_src;
    logic       in_exec;
    logic       retire;

    assign opcode = instr_q[6:0];
    assign rd     = instr_q[11:7];
    assign funct3 = instr_q[14:12];
    assign funct7 = instr_q[31:25];

    assign op_r  = (opcode == 7'b0110011);
    assign op_i  = (opcode == 7'b0010011);
    assign op_lw = (opcode == 7'b0000011);
    assign op_sw = (opcode == 7'b0100011);

    always_comb begin
        f3_ok = 1'b1;
        f3_op = 4'b0000;
        unique case (funct3)
            3'b000:  f3_op = 4'b0010;
            3'b111:  f3_op = 4'b0000;
            3'b110:  f3_op = 4'b0001;
            3'b010:  f3_op = 4'b0111;
            default: f3_ok = 1'b0;
        endcase
    end

    always_comb begin
        legal   = 1'b0;
        dec_op  = 4'b0000;
        dec_src = 1'b0;
        unique case (1'b1)
            op_r: begin
                dec_op = f3_op;
                if (funct7 == 7'b0000000) begin
                    legal = f3_ok;
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    legal  = 1'b1;
                    dec_op = 4'b0110;
                end
            end
            op_i: begin
                legal   = f3_ok;
                dec_op  = f3_op;
                dec_src = 1'b1;
            end
            op_lw, op_sw: begin
                legal   = (funct3 == 3'b010);
                dec_op  = 4'b0010;
                dec_src = 1'b1;
            end
            default: ;
        endcase
    end

    // sw retires directly out of MEM, everything else out of WB
    assign retire = (state == WB)
                 || (state == MEM && op_sw && bus.mem_ready);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.instr_valid) state_nx = DECODE;
            DECODE:  state_nx = legal ? EXEC : IDLE;
            EXEC:    state_nx = (op_lw || op_sw) ? MEM : WB;
            MEM:     if (bus.mem_ready) state_nx = op_lw ? WB : IDLE;
            WB:      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            instr_q   <= '0;
            retired_q <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && bus.instr_valid) instr_q <= bus.instr_in;
            if (retire) retired_q <= retired_q + 1'b1;
        end
    end

    assign in_exec = (state == EXEC) || (state == MEM) || (state == WB);

    assign bus.instr_ready = (state == IDLE);
    assign bus.instruction = instr_q;
    assign bus.ALUSrc      = in_exec & dec_src;
    assign bus.ALUop       = in_exec ? dec_op : 4'b0000;
    assign bus.MemRead     = (state == MEM) && op_lw;
    assign bus.MemWrite    = (state == MEM) && op_sw;
    assign bus.RegWrite    = (state == WB) && (rd != 5'd0);
    assign bus.MemtoReg    = (state == WB) && op_lw;
    assign bus.done        = retire;
    assign bus.illegal     = (state == DECODE) && !legal;
    assign bus.retired     = retired_q;
endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: stimulus queues expected
// retire/illegal records, a negedge monitor pops and compares them.
module tb_multicycle_control;
    localparam int RW = 4;

    typedef struct {
        logic        ill;
        logic [31:0] ins;
        int          lat;
        int          rw;
        int          mc;
        logic [3:0]  op;
        logic        src;
        logic        m2r;
        logic [RW-1:0] ret;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   passed = 0;
    exp_t sb[$];
    logic [RW-1:0] exp_ret = '0;

    multicycle_control_if #(.RETIRE_W(RW)) bus ();

    multicycle_control #(.RETIRE_W(RW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] want);
        checks++;
        if (got === want) passed++;
        else $display("FAIL %s: got %h want %h", name, got, want);
    endtask

    function automatic exp_t mk(input logic ill, input logic [31:0] ins,
                                input int lat, input int rw, input int mc,
                                input logic [3:0] op, input logic src,
                                input logic m2r);
        exp_t e;
        e.ill = ill;
        e.ins = ins;
        e.lat = lat;
        e.rw  = rw;
        e.mc  = mc;
        e.op  = op;
        e.src = src;
        e.m2r = m2r;
        e.ret = '0;
        return e;
    endfunction

    // monitor
    int cyc = 0;
    int acc = 0;
    int rw  = 0;
    int mc  = 0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            rw = 0;
            mc = 0;
        end else begin
            cyc++;
            if (bus.instr_valid && bus.instr_ready) begin
                acc = cyc;
                rw  = 0;
                mc  = 0;
            end
            if (bus.RegWrite) rw++;
            if (bus.MemRead || bus.MemWrite) mc++;
            if (bus.instr_ready)
                check("idle_ctrl",
                      {bus.RegWrite, bus.ALUSrc, bus.ALUop, bus.MemWrite,
                       bus.MemRead, bus.MemtoReg, bus.done, bus.illegal},
                      32'd0);
            if (bus.done || bus.illegal) begin
                if (sb.size() == 0) begin
                    check("unexpected_event", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("illegal_flag", bus.illegal, e.ill);
                    check("done_flag", bus.done, !e.ill);
                    check("instruction", bus.instruction, e.ins);
                    check("latency", cyc - acc, e.lat);
                    check("regwrite_cycles", rw, e.rw);
                    check("mem_cycles", mc, e.mc);
                    check("aluop", bus.ALUop, e.op);
                    check("alusrc", bus.ALUSrc, e.src);
                    check("memtoreg", bus.MemtoReg, e.m2r);
                    check("retired", bus.retired, e.ret);
                end
            end
        end
    end

    // called at posedge+1 with the DUT idle
    task automatic run(input logic [31:0] ins, input int waits,
                       input exp_t e0);
        exp_t e;
        int   seen;
        bit   fin;
        e     = e0;
        seen  = 0;
        fin   = 0;
        e.ret = exp_ret;
        if (!e.ill) exp_ret = exp_ret + 1'b1;
        sb.push_back(e);
        bus.instr_valid = 1'b1;
        bus.instr_in    = ins;
        bus.mem_ready   = (waits == 0);
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        bus.instr_in    = 32'hFFFF_FFFF;
        for (int k = 0; k < 60 && !fin; k++) begin
            if (bus.MemRead || bus.MemWrite) begin
                seen++;
                if (seen > waits) bus.mem_ready = 1'b1;
            end
            #1;
            if (bus.done || bus.illegal) fin = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!fin) begin
            check("timeout", 32'd0, 32'd1);
            sb.delete();
        end
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;
    endtask

    initial begin
        rst_n           = 1'b0;
        bus.instr_valid = 1'b0;
        bus.instr_in    = 32'h0;
        bus.mem_ready   = 1'b0;
        #3;
        check("rst_ready", bus.instr_ready, 32'd1);
        check("rst_instruction", bus.instruction, 32'd0);
        check("rst_retired", bus.retired, 32'd0);
        check("rst_ctrl",
              {bus.RegWrite, bus.ALUSrc, bus.ALUop, bus.MemWrite,
               bus.MemRead, bus.MemtoReg, bus.done, bus.illegal},
              32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run(32'h00208433, 0, mk(0, 32'h00208433, 3, 1, 0, 4'b0010, 0, 0));
        run(32'h0000A403, 3, mk(0, 32'h0000A403, 7, 1, 4, 4'b0010, 1, 1));
        run(32'h0080A023, 0, mk(0, 32'h0080A023, 3, 0, 1, 4'b0010, 1, 0));
        run(32'h40208033, 0, mk(0, 32'h40208033, 3, 0, 0, 4'b0110, 0, 0));
        run(32'h0000007F, 0, mk(1, 32'h0000007F, 1, 0, 0, 4'b0000, 0, 0));
        run(32'h00209433, 0, mk(1, 32'h00209433, 1, 0, 0, 4'b0000, 0, 0));
        run(32'h02208433, 0, mk(1, 32'h02208433, 1, 0, 0, 4'b0000, 0, 0));
        run(32'h00008403, 0, mk(1, 32'h00008403, 1, 0, 0, 4'b0000, 0, 0));
        run(32'h00500093, 0, mk(0, 32'h00500093, 3, 1, 0, 4'b0010, 1, 0));
        run(32'h0050E093, 0, mk(0, 32'h0050E093, 3, 1, 0, 4'b0001, 1, 0));
        run(32'h0020A433, 0, mk(0, 32'h0020A433, 3, 1, 0, 4'b0111, 0, 0));
        run(32'h0020F433, 0, mk(0, 32'h0020F433, 3, 1, 0, 4'b0000, 0, 0));
        run(32'h0080A023, 2, mk(0, 32'h0080A023, 5, 0, 3, 4'b0010, 1, 0));

        // abandon a lw mid-MEM
        bus.instr_valid = 1'b1;
        bus.instr_in    = 32'h0000A403;
        bus.mem_ready   = 1'b0;
        @(posedge clk);
        #1;
        bus.instr_valid = 1'b0;
        for (int k = 0; k < 10 && !bus.MemRead; k++) begin
            @(posedge clk);
            #1;
        end
        check("mid_memread_before", bus.MemRead, 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_memread", bus.MemRead, 32'd0);
        check("mid_ready", bus.instr_ready, 32'd1);
        check("mid_retired", bus.retired, 32'd0);
        check("mid_done", bus.done, 32'd0);
        exp_ret = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++)
            run(32'h0080A023, 0, mk(0, 32'h0080A023, 3, 0, 1, 4'b0010, 1, 0));
        check("retired_wrap", bus.retired, 32'd0);
        check("queue_empty", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
